rf_write_arbiter: RTL and testbench

// - Owns the single write port of reg_file (16 x DATA_W, sync write / async read).
// - After every reset, clears all registers to zero with a sequencer, then shares the write port between two requesters.
// - Requester A is ALU writeback; requester B is load/IO writeback. Both use valid/ready; fairness is round-robin.
// - Sits between the writeback stage and reg_file; read ports stay wired directly to the datapath.

---
 rtl/rf_write_arbiter_pkg.sv | 12 +
 rtl/reg_file.sv | 25 ++
 rtl/rf_write_arbiter.sv | 92 +++++++++
 tb/tb_rf_write_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths and encodings for the register-file write arbiter.
package rf_write_arbiter_pkg;

  localparam int RFA_DATA_W = 16;
  localparam int RFA_ADDR_W = 4;

  localparam logic [0:0] RFA_CLEAR = 1'b0;
  localparam logic [0:0] RFA_RUN   = 1'b1;
  localparam logic [0:0] PRIO_A    = 1'b0;
  localparam logic [0:0] PRIO_B    = 1'b1;

endpackage

// File: rtl/reg_file.sv
// 2**ADDR_W x DATA_W register file: synchronous write, two asynchronous read ports.
module reg_file import rf_write_arbiter_pkg::*; #(
  parameter int DATA_W = RFA_DATA_W,
  parameter int ADDR_W = RFA_ADDR_W
) (
  input  logic              clock_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  output logic [DATA_W-1:0] r1_data_o,
  input  logic [ADDR_W-1:0] r2_addr_i,
  output logic [DATA_W-1:0] r2_data_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock_i) begin
    if (we_i) mem[w_addr_i] <= w_data_i;
  end

  assign r1_data_o = mem[r1_addr_i];
  assign r2_data_o = mem[r2_addr_i];

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: zero-fills every register after reset,
// then round-robin arbitrates ALU (A) and load/IO (B) writebacks.
module rf_write_arbiter import rf_write_arbiter_pkg::*; #(
  parameter int DATA_W = RFA_DATA_W,
  parameter int ADDR_W = RFA_ADDR_W
) (
  input  logic              clock_i,
  input  logic              n_rst_i,
  input  logic              a_valid_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              busy_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_w_addr_o,
  output logic [DATA_W-1:0] rf_w_data_o
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  logic [0:0]        state_q, state_d;
  logic [0:0]        prio_q, prio_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              run, a_acc, b_acc;

  // Readiness looks only at the other side's valid so a requester never loops on itself.
  assign run       = (state_q == RFA_RUN);
  assign a_ready_o = run & (~b_valid_i | (prio_q == PRIO_A));
  assign b_ready_o = run & (~a_valid_i | (prio_q == PRIO_B));
  assign a_acc     = a_valid_i & a_ready_o;
  assign b_acc     = b_valid_i & b_ready_o;
  assign busy_o    = ~run;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    clr_cnt_d = clr_cnt_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    if (state_q == RFA_CLEAR) begin
      we_d      = 1'b1;
      waddr_d   = clr_cnt_q;
      wdata_d   = '0;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_REG) state_d = RFA_RUN;
    end else begin
      if (a_acc) begin
        we_d    = 1'b1;
        waddr_d = a_addr_i;
        wdata_d = a_data_i;
      end else if (b_acc) begin
        we_d    = 1'b1;
        waddr_d = b_addr_i;
        wdata_d = b_data_i;
      end
      // Priority only moves on contention, handing it to whoever just lost.
      if (a_valid_i && b_valid_i) prio_d = a_acc ? PRIO_B : PRIO_A;
    end
  end

  always_ff @(posedge clock_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q   <= RFA_CLEAR;
      prio_q    <= PRIO_A;
      clr_cnt_q <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      clr_cnt_q <= clr_cnt_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign rf_we_o     = we_q;
  assign rf_w_addr_o = waddr_q;
  assign rf_w_data_o = wdata_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter + reg_file: directed scenarios plus a random
// traffic run against a transaction-level model of the register file.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        av = 1'b0, bv = 1'b0;
  logic [3:0]  aa = '0, ba = '0, r1a = '0, r2a = '0;
  logic [15:0] ad = '0, bd = '0;
  logic        a_ready, b_ready, busy, rf_we;
  logic [3:0]  rf_w_addr;
  logic [15:0] rf_w_data, r1d, r2d;

  int errors = 0;
  int checks = 0;

  // Model: register contents, the write in flight to the file, and whether B
  // is owed the next contended grant.
  logic [15:0] mregs [16];
  bit          favour_b;
  bit          pend_we;
  logic [3:0]  pend_addr;
  logic [15:0] pend_data;

  always #10 clk = ~clk;

  rf_write_arbiter dut (
    .clock_i(clk), .n_rst_i(n_rst),
    .a_valid_i(av), .a_addr_i(aa), .a_data_i(ad), .a_ready_o(a_ready),
    .b_valid_i(bv), .b_addr_i(ba), .b_data_i(bd), .b_ready_o(b_ready),
    .busy_o(busy), .rf_we_o(rf_we), .rf_w_addr_o(rf_w_addr), .rf_w_data_o(rf_w_data)
  );

  reg_file rf (
    .clock_i(clk), .we_i(rf_we), .w_addr_i(rf_w_addr), .w_data_i(rf_w_data),
    .r1_addr_i(r1a), .r1_data_o(r1d), .r2_addr_i(r2a), .r2_data_o(r2d)
  );

  // One RUN cycle: drive, check readiness, predict winner, check the output stage and reads.
  task automatic step(input bit a_v, input logic [3:0] a_a, input logic [15:0] a_d,
                      input bit b_v, input logic [3:0] b_a, input logic [15:0] b_d,
                      input logic [3:0] ra1, input logic [3:0] ra2, output int win);
    bit ea, eb;
    @(negedge clk);
    av = a_v; aa = a_a; ad = a_d; bv = b_v; ba = b_a; bd = b_d; r1a = ra1; r2a = ra2;
    #1;
    ea = a_v && (!b_v || !favour_b);
    eb = b_v && (!a_v || favour_b);
    win = ea ? 1 : (eb ? 2 : 0);
    if (a_v && b_v) favour_b = (win == 1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL run_busy got=%b exp=0", busy); end
    checks++;
    if ((a_ready & a_v) !== ea || (b_ready & b_v) !== eb)
      begin errors++; $display("FAIL accept got a=%b b=%b exp a=%b b=%b", a_ready & a_v, b_ready & b_v, ea, eb); end
    if (!b_v) begin
      checks++;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL a_ready_free got=%b exp=1", a_ready); end
    end
    @(posedge clk);
    if (pend_we) mregs[pend_addr] = pend_data;
    pend_we = (win != 0);
    if (win == 1) begin pend_addr = a_a; pend_data = a_d; end
    if (win == 2) begin pend_addr = b_a; pend_data = b_d; end
    #1;
    checks++;
    if (rf_we !== pend_we) begin errors++; $display("FAIL rf_we got=%b exp=%b", rf_we, pend_we); end
    if (pend_we) begin
      checks++;
      if (rf_w_addr !== pend_addr || rf_w_data !== pend_data)
        begin errors++; $display("FAIL rf_w got=%h/%h exp=%h/%h", rf_w_addr, rf_w_data, pend_addr, pend_data); end
    end
    checks++;
    if (r1d !== mregs[ra1] || r2d !== mregs[ra2])
      begin errors++; $display("FAIL readback r1[%0d]=%h r2[%0d]=%h exp %h %h", ra1, r1d, ra2, r2d, mregs[ra1], mregs[ra2]); end
  endtask

  task automatic idle(input logic [3:0] ra1, input logic [3:0] ra2);
    int w;
    step(0, 4'd0, 16'd0, 0, 4'd0, 16'd0, ra1, ra2, w);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || a_ready !== 1'b0 || b_ready !== 1'b0)
      begin errors++; $display("FAIL reset_ctl busy=%b ar=%b br=%b exp 1 0 0", busy, a_ready, b_ready); end
    checks++;
    if (rf_we !== 1'b0 || rf_w_addr !== 4'd0 || rf_w_data !== 16'd0)
      begin errors++; $display("FAIL reset_out we=%b addr=%h data=%h exp 0 0 0", rf_we, rf_w_addr, rf_w_data); end
  endtask

  // Releases reset and follows the zero-fill, register by register.
  task automatic run_clear();
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || a_ready !== 1'b0 || b_ready !== 1'b0)
        begin errors++; $display("FAIL clear_ctl k=%0d busy=%b ar=%b br=%b exp 1 0 0", k, busy, a_ready, b_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (rf_we !== 1'b1 || rf_w_addr !== 4'(k) || rf_w_data !== 16'd0)
        begin errors++; $display("FAIL clear_out k=%0d we=%b addr=%0d data=%h exp 1 %0d 0", k, rf_we, rf_w_addr, rf_w_data, k); end
      if (k < 15) @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL clear_done busy=%b exp=0", busy); end
    for (int i = 0; i < 16; i++) mregs[i] = 16'd0;
    favour_b = 0; pend_we = 1; pend_addr = 4'd15; pend_data = 16'd0;
  endtask

  task automatic test_reset();
    apply_reset();
    run_clear();
  endtask

  task automatic test_clear_readback();
    for (int k = 0; k < 16; k += 2) begin
      idle(4'(k), 4'(k + 1));
      checks++;
      if (r1d !== 16'h0000 || r2d !== 16'h0000)
        begin errors++; $display("FAIL cleared r%0d=%h r%0d=%h exp 0000", k, r1d, k + 1, r2d); end
    end
  endtask

  task automatic test_a_only();
    int w;
    step(1, 4'd8, 16'h8000, 0, 4'd0, 16'd0, 4'd0, 4'd0, w);
    checks++;
    if (w != 1 || a_ready !== 1'b1) begin errors++; $display("FAIL a_only win=%0d exp=1", w); end
    idle(4'd8, 4'd0);
    checks++;
    if (r1d !== 16'h8000) begin errors++; $display("FAIL a_only_read got=%h exp=8000", r1d); end
  endtask

  task automatic test_both_alternate();
    int w;
    int seq [4];
    int expseq [4] = '{1, 2, 1, 2};
    for (int i = 0; i < 4; i++) begin
      step(1, 4'd3, 16'h0003, 1, 4'd5, 16'h0005, 4'd0, 4'd0, w);
      seq[i] = w;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seq[i] != expseq[i]) begin errors++; $display("FAIL alternate[%0d] got=%0d exp=%0d", i, seq[i], expseq[i]); end
    end
    idle(4'd0, 4'd0);
    idle(4'd3, 4'd5);
    checks++;
    if (r1d !== 16'h0003 || r2d !== 16'h0005)
      begin errors++; $display("FAIL alternate_read r3=%h r5=%h exp 0003 0005", r1d, r2d); end
  endtask

  task automatic test_same_addr();
    int w1, w2;
    step(1, 4'd8, 16'h1111, 1, 4'd8, 16'h2222, 4'd0, 4'd0, w1);
    step(0, 4'd0, 16'd0, 1, 4'd8, 16'h2222, 4'd0, 4'd0, w2);
    checks++;
    if (w1 != 1 || w2 != 2) begin errors++; $display("FAIL same_addr order got=%0d,%0d exp=1,2", w1, w2); end
    idle(4'd0, 4'd0);
    idle(4'd8, 4'd8);
    checks++;
    if (r1d !== 16'h2222) begin errors++; $display("FAIL same_addr_read got=%h exp=2222", r1d); end
  endtask

  task automatic test_random();
    bit         pa = 0, pb = 0, va, vb;
    logic [3:0] xa, xb;
    logic [15:0] da, db;
    int w;
    for (int n = 0; n < 300; n++) begin
      if (!pa) begin va = ($urandom_range(0, 2) != 0); xa = 4'($urandom); da = 16'($urandom); end
      if (!pb) begin vb = ($urandom_range(0, 2) != 0); xb = 4'($urandom); db = 16'($urandom); end
      step(va, xa, da, vb, xb, db, 4'($urandom), 4'($urandom), w);
      pa = va && (w != 1);
      pb = vb && (w != 2);
    end
    bv = 1'b0;
    idle(4'd0, 4'd1);
    idle(4'd2, 4'd3);
  endtask

  task automatic test_preload_reset();
    int w;
    step(1, 4'd8, 16'hFFFF, 0, 4'd0, 16'd0, 4'd0, 4'd0, w);
    idle(4'd8, 4'd0);
    checks++;
    if (r1d !== 16'hFFFF) begin errors++; $display("FAIL preload got=%h exp=ffff", r1d); end
    apply_reset();
    run_clear();
    idle(4'd8, 4'd15);
    checks++;
    if (r1d !== 16'h0000 || r2d !== 16'h0000)
      begin errors++; $display("FAIL preload_cleared r8=%h r15=%h exp 0000", r1d, r2d); end
  endtask

  task automatic test_valid_during_clear();
    int w;
    av = 1'b1; aa = 4'd2; ad = 16'h1234;
    apply_reset();
    run_clear();
    step(1, 4'd2, 16'h1234, 0, 4'd0, 16'd0, 4'd0, 4'd0, w);
    checks++;
    if (w != 1) begin errors++; $display("FAIL clear_wait_accept win=%0d exp=1", w); end
    idle(4'd2, 4'd0);
    checks++;
    if (r1d !== 16'h1234) begin errors++; $display("FAIL clear_wait_read got=%h exp=1234", r1d); end
  endtask

  task automatic test_mid_clear_reset();
    apply_reset();
    @(negedge clk);
    n_rst = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if (rf_we !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL mid_clear_reset we=%b busy=%b exp 0 1", rf_we, busy); end
    run_clear();
    idle(4'd4, 4'd14);
  endtask

  initial begin
    test_reset();
    test_clear_readback();
    test_a_only();
    test_both_alternate();
    test_same_addr();
    test_random();
    test_preload_reset();
    test_valid_during_clear();
    test_mid_clear_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
